// File: rtl/scan_pkg.sv
// Shared types and helpers for the 3-D scan address generator.
// Holds the FSM state enum, the bound clamp and the counter-width helper.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width for n positions, never below one bit.
   function automatic int bits(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic int clamp(input int v, input int hi);
      if (v < 1) return 1;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/scan_axis_cntr.sv
// One wrapping scan axis: counts toward its last index and wraps on en.
// BOUNCE makes the wrap hold the value so an external direction flip reverses it.
module scan_axis_cntr #(
   parameter int W      = 1,
   parameter bit BOUNCE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] bound,
   input  logic         dir,
   output logic [W-1:0] value,
   output logic         at_last
);

   logic [W-1:0] value_q, value_d;

   always_comb begin
      at_last = dir ? (value_q == '0) : (value_q == bound);
   end

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (en) begin
         if (at_last) begin
            if (BOUNCE) value_d = value_q;
            else        value_d = dir ? bound : '0;
         end else begin
            value_d = dir ? value_q - W'(1) : value_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) value_q <= '0;
      else     value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/scan_addr_gen.sv
// Programmable pixel x slice x channel scan generator with stall and done pulse.
// Define SERPENTINE_EN to alternate pixel direction on every global slice.
module scan_addr_gen
   import scan_pkg::*;
#(
   parameter  int MAX_W = 32,
   parameter  int MAX_H = 32,
   parameter  int MAX_C = 4,
   localparam int PW    = bits(MAX_W),
   localparam int SW    = bits(MAX_H),
   localparam int CW    = bits(MAX_C),
   localparam int AW    = bits(MAX_W * MAX_H * MAX_C),
   localparam int WW    = $clog2(MAX_W + 1),
   localparam int HW    = $clog2(MAX_H + 1),
   localparam int CCW   = $clog2(MAX_C + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [WW-1:0]  cfg_w,
   input  logic [HW-1:0]  cfg_h,
   input  logic [CCW-1:0] cfg_c,
   input  logic           start,
   input  logic           stall,
   output logic           busy,
   output logic           valid,
   output logic [PW-1:0]  pixel_cntr,
   output logic [SW-1:0]  slice_cntr,
   output logic [CW-1:0]  chan_cntr,
   output logic           last_pixel,
   output logic           last_slice,
   output logic [AW-1:0]  lin_addr,
   output logic           done
);

   state_e        state_q, state_d;
   logic [PW-1:0] lim_w_q, lim_w_d;
   logic [SW-1:0] lim_h_q, lim_h_d;
   logic [CW-1:0] lim_c_q, lim_c_d;
   logic [AW-1:0] lin_q, lin_d;
   logic          go, adv, fin, step;
   logic          px_en, sl_en, ch_en;
   logic          px_last, sl_last, ch_last;
   logic          px_dir;

   assign go    = (state_q == IDLE) && start;
   assign adv   = (state_q == RUN) && !stall;
   assign fin   = adv && px_last && sl_last && ch_last;
   assign step  = adv && !fin;
   assign px_en = step;
   assign sl_en = step && px_last;
   assign ch_en = sl_en && sl_last;

`ifdef SERPENTINE_EN
   localparam bit BOUNCE = 1'b1;
   logic odd_q, odd_d;

   always_comb begin
      odd_d = odd_q;
      if (go)                     odd_d = 1'b0;
      else if (px_en && px_last)  odd_d = ~odd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) odd_q <= 1'b0;
      else     odd_q <= odd_d;
   end

   assign px_dir = odd_q;
`else
   localparam bit BOUNCE = 1'b0;
   assign px_dir = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lim_w_q <= '0;
         lim_h_q <= '0;
         lim_c_q <= '0;
         lin_q   <= '0;
      end else begin
         state_q <= state_d;
         lim_w_q <= lim_w_d;
         lim_h_q <= lim_h_d;
         lim_c_q <= lim_c_d;
         lin_q   <= lin_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (fin)   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bounds are stored as last index so a latched size of 1 resets to 0.
   always_comb begin
      lim_w_d = lim_w_q;
      lim_h_d = lim_h_q;
      lim_c_d = lim_c_q;
      lin_d   = lin_q;
      if (go) begin
         lim_w_d = PW'(clamp(int'(cfg_w), MAX_W) - 1);
         lim_h_d = SW'(clamp(int'(cfg_h), MAX_H) - 1);
         lim_c_d = CW'(clamp(int'(cfg_c), MAX_C) - 1);
         lin_d   = '0;
      end else if (step) begin
         lin_d = lin_q + AW'(1);
      end
   end

   always_comb begin
      valid      = (state_q == RUN);
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
      last_pixel = valid && px_last;
      last_slice = valid && sl_last;
      lin_addr   = lin_q;
   end

   scan_axis_cntr #(.W(PW), .BOUNCE(BOUNCE)) u_pixel (
      .clk     (clk),
      .rst     (rst),
      .clr     (go),
      .en      (px_en),
      .bound   (lim_w_q),
      .dir     (px_dir),
      .value   (pixel_cntr),
      .at_last (px_last)
   );

   scan_axis_cntr #(.W(SW), .BOUNCE(1'b0)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .clr     (go),
      .en      (sl_en),
      .bound   (lim_h_q),
      .dir     (1'b0),
      .value   (slice_cntr),
      .at_last (sl_last)
   );

   scan_axis_cntr #(.W(CW), .BOUNCE(1'b0)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .clr     (go),
      .en      (ch_en),
      .bound   (lim_c_q),
      .dir     (1'b0),
      .value   (chan_cntr),
      .at_last (ch_last)
   );

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed bench for scan_addr_gen: sizes, clamping, stall, restart and reset.
// Pixel order follows SERPENTINE_EN when the macro is defined.
module tb_scan_addr_gen;

`ifdef SERPENTINE_EN
   localparam bit SERP = 1'b1;
`else
   localparam bit SERP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] cfg_w = '0;
   logic [5:0] cfg_h = '0;
   logic [2:0] cfg_c = '0;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic       busy, valid, last_pixel, last_slice, done;
   logic [4:0] pixel_cntr;
   logic [4:0] slice_cntr;
   logic [1:0] chan_cntr;
   logic [11:0] lin_addr;

   int errs = 0;
   int checks = 0;
   int cur = -1;

   scan_addr_gen dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_w      (cfg_w),
      .cfg_h      (cfg_h),
      .cfg_c      (cfg_c),
      .start      (start),
      .stall      (stall),
      .busy       (busy),
      .valid      (valid),
      .pixel_cntr (pixel_cntr),
      .slice_cntr (slice_cntr),
      .chan_cntr  (chan_cntr),
      .last_pixel (last_pixel),
      .last_slice (last_slice),
      .lin_addr   (lin_addr),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errs++;
         $display("FAIL %s idx=%0d got=%0d exp=%0d", tag, cur, obs, exp);
      end
   endtask

   task automatic chk_pos(input int i, input int ew, input int eh,
                          input int ec, input bit live);
      int px, sl, ch;
      px = i % ew;
      sl = (i / ew) % eh;
      ch = i / (ew * eh);
      if (SERP && ((i / ew) % 2 == 1)) px = ew - 1 - px;
      cur = i;
      chk("valid", valid, live);
      chk("pixel", pixel_cntr, px);
      chk("slice", slice_cntr, sl);
      chk("chan", chan_cntr, ch);
      chk("lin", lin_addr, i);
      if (live) begin
         chk("last_px", last_pixel, (i % ew) == ew - 1);
         chk("last_sl", last_slice, sl == eh - 1);
         chk("busy", busy, 1);
         chk("done", done, 0);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_lpx"}, last_pixel, 0);
      chk({tag, "_lsl"}, last_slice, 0);
   endtask

   task automatic scan(input int cw, input int ch, input int cc,
                       input int ew, input int eh, input int ec,
                       input int st_at, input int st_len);
      int n;
      n = ew * eh * ec;
      cfg_w = 6'(cw);
      cfg_h = 6'(ch);
      cfg_c = 3'(cc);
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_w = 6'd2;
      cfg_h = 6'd3;
      cfg_c = 3'd3;
      for (int i = 0; i < n; i++) begin
         chk_pos(i, ew, eh, ec, 1'b1);
         if (i == st_at) begin
            stall = 1'b1;
            for (int k = 0; k < st_len; k++) begin
               tick();
               chk_pos(i, ew, eh, ec, 1'b1);
            end
            stall = 1'b0;
         end
         tick();
      end
      chk_pos(n - 1, ew, eh, ec, 1'b0);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      tick();
      chk_idle("after_done");
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk_idle("reset");
      chk("reset_px", pixel_cntr, 0);
      chk("reset_lin", lin_addr, 0);
      stall = 1'b1;
      tick();
      stall = 1'b0;
      chk_idle("stall_idle");

      // 4x2x1 straight scan
      scan(4, 2, 1, 4, 2, 1, -1, 0);
      // same with a 3-cycle stall at sequence index 5
      scan(4, 2, 1, 4, 2, 1, 5, 3);
      // clamp: w 0 -> 1, h 40 -> 32
      scan(0, 40, 2, 1, 32, 2, -1, 0);

      // restart attempt and cfg change mid-run, then reset at index 3
      cfg_w = 6'd4;
      cfg_h = 6'd2;
      cfg_c = 3'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_pos(i, 4, 2, 1, 1'b1);
         start = (i == 1);
         if (i == 1) begin
            cfg_w = 6'd2;
            cfg_h = 6'd1;
         end
         rst = (i == 3);
         tick();
      end
      start = 1'b0;
      rst = 1'b0;
      cur = -1;
      chk_idle("mid_rst");
      chk("mid_rst_px", pixel_cntr, 0);
      chk("mid_rst_sl", slice_cntr, 0);
      chk("mid_rst_lin", lin_addr, 0);
      tick();
      chk_idle("post_rst");

      // single-position scan
      scan(1, 1, 1, 1, 1, 1, -1, 0);
      // fresh normal scan after everything else
      scan(3, 2, 1, 3, 2, 1, -1, 0);
      scan(2, 2, 4, 2, 2, 4, 2, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
